// File: rtl/s9234_n676_ctrl_if.sv
// Request/result handshake bundle for the s9234_n676 compare/parity controller.
// The master side is the requester/consumer; the slave side is the controller.
`timescale 1ns/1ps
interface s9234_n676_ctrl_if #(
    parameter int TAGW = 8,
    parameter int PARW = 7
);
    logic            in_valid;
    logic            in_ready;
    logic [TAGW-1:0] tag_a;
    logic [TAGW-1:0] tag_b;
    logic [PARW-1:0] par_vec;
    logic [3:0]      gate_n;
    logic            sel_hold;
    logic            out_valid;
    logic            out_ready;
    logic            q;
    logic            match;
    logic            parity;
    logic [7:0]      err_cnt;

    modport master (
        output in_valid, tag_a, tag_b, par_vec, gate_n, sel_hold, out_ready,
        input  in_ready, out_valid, q, match, parity, err_cnt
    );

    modport slave (
        input  in_valid, tag_a, tag_b, par_vec, gate_n, sel_hold, out_ready,
        output in_ready, out_valid, q, match, parity, err_cnt
    );
endinterface

// File: rtl/s9234_n676_ctrl.sv
// Five-state request controller: captures a request, compares tags, reduces parity,
// conditionally updates q and a saturating error count, then holds the result until taken.
`timescale 1ns/1ps
module s9234_n676_ctrl #(
    parameter int TAGW = 8,
    parameter int PARW = 7
) (
    input  logic             CK,
    input  logic             RSTN,
    s9234_n676_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CMP, PAR, UPD, OUT} state_t;

    state_t          state, state_nx;
    logic            ready_r, valid_r;
    logic            q_r, match_r, parity_r;
    logic [7:0]      err_r;
    logic [TAGW-1:0] tag_a_r, tag_b_r;
    logic [PARW-1:0] par_r;
    logic [3:0]      gate_r;
    logic            hold_r;
    logic            accept;
    logic            gate_open;
    logic            load;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid && ready_r) begin
                    accept   = 1'b1;
                    state_nx = CMP;
                end
            end
            CMP:     state_nx = PAR;
            PAR:     state_nx = UPD;
            UPD:     state_nx = OUT;
            OUT:     if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign gate_open = (gate_r == '0);
    assign load      = gate_open & ~hold_r;

    // Handshake flags are registered from the next state so that in_ready stays low
    // in the IDLE state forced by reset until the first clock edge after release.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state   <= IDLE;
            ready_r <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state   <= state_nx;
            ready_r <= (state_nx == IDLE);
            valid_r <= (state_nx == OUT);
        end
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            tag_a_r  <= '0;
            tag_b_r  <= '0;
            par_r    <= '0;
            gate_r   <= '0;
            hold_r   <= 1'b0;
            q_r      <= 1'b0;
            match_r  <= 1'b0;
            parity_r <= 1'b0;
            err_r    <= '0;
        end else begin
            if (accept) begin
                tag_a_r <= bus.tag_a;
                tag_b_r <= bus.tag_b;
                par_r   <= bus.par_vec;
                gate_r  <= bus.gate_n;
                hold_r  <= bus.sel_hold;
            end
            case (state)
                CMP: match_r  <= (tag_a_r == tag_b_r);
                PAR: parity_r <= ^par_r;
                UPD: begin
                    if (load) q_r <= match_r & ~parity_r;
                    // sel_hold only blocks q; a mismatch under open gates still counts
                    if (gate_open && !match_r && (err_r != '1)) err_r <= err_r + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = ready_r;
    assign bus.out_valid = valid_r;
    assign bus.q         = q_r;
    assign bus.match     = match_r;
    assign bus.parity    = parity_r;
    assign bus.err_cnt   = err_r;
endmodule

// File: tb/tb_s9234_n676_ctrl.sv
// Directed bench for s9234_n676_ctrl: reset, compare/parity/update outcomes, stall,
// back-to-back spacing, error-count saturation and mid-request reset.
`timescale 1ns/1ps
module tb_s9234_n676_ctrl;
    logic CK;
    logic RSTN;
    int   vectors;
    int   errors;

    s9234_n676_ctrl_if #(.TAGW(8), .PARW(7)) bus ();

    s9234_n676_ctrl #(.TAGW(8), .PARW(7)) dut (
        .CK   (CK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input string tag, input logic [7:0] ta, input logic [7:0] tbv,
                           input logic [6:0] pv, input logic [3:0] gn, input logic sh,
                           input logic eq, input logic em, input logic ep, input logic [7:0] ee);
        int w;
        int lat;
        bus.out_ready = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(negedge CK);
            w++;
        end
        check({tag, "/idle"}, 32'(bus.in_ready), 32'd1);
        bus.tag_a    = ta;
        bus.tag_b    = tbv;
        bus.par_vec  = pv;
        bus.gate_n   = gn;
        bus.sel_hold = sh;
        bus.in_valid = 1'b1;
        @(negedge CK);
        // Scramble inputs after accept: the captured copies must be used.
        bus.in_valid = 1'b0;
        bus.tag_a    = (ta == tbv) ? ~ta : ta;
        bus.tag_b    = ta;
        bus.par_vec  = ~pv;
        bus.gate_n   = ~gn;
        bus.sel_hold = ~sh;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge CK);
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'd4);
        check({tag, "/q"},       32'(bus.q), 32'(eq));
        check({tag, "/match"},   32'(bus.match), 32'(em));
        check({tag, "/parity"},  32'(bus.parity), 32'(ep));
        check({tag, "/err_cnt"}, 32'(bus.err_cnt), 32'(ee));
        check({tag, "/busy"},    32'(bus.in_ready), 32'd0);
        @(negedge CK);
        check({tag, "/done"},    32'(bus.out_valid), 32'd0);
        check({tag, "/ready"},   32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int w;
        int n;
        int prev;
        vectors       = 0;
        errors        = 0;
        RSTN          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.tag_a     = '0;
        bus.tag_b     = '0;
        bus.par_vec   = '0;
        bus.gate_n    = '0;
        bus.sel_hold  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        @(negedge CK);
        check("rst/in_ready",  32'(bus.in_ready), 32'd0);
        check("rst/out_valid", 32'(bus.out_valid), 32'd0);
        check("rst/q",         32'(bus.q), 32'd0);
        check("rst/err_cnt",   32'(bus.err_cnt), 32'd0);
        @(negedge CK);
        RSTN = 1'b1;
        #1;
        check("rel/in_ready_pre", 32'(bus.in_ready), 32'd0);
        @(negedge CK);
        check("rel/in_ready_post", 32'(bus.in_ready), 32'd1);

        // Functional vectors
        run_req("r1_match",    8'h5A, 8'h5A, 7'b0000011, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        run_req("r2_mismatch", 8'h5A, 8'h5B, 7'b0000000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        run_req("r3_set_q",    8'hC3, 8'hC3, 7'b0000000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1);
        run_req("r4_gated",    8'h5A, 8'h5B, 7'b0000000, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        run_req("r5_hold",     8'h5A, 8'h5B, 7'b0000000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
        run_req("r6_odd_par",  8'h33, 8'h33, 7'b0000111, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2);
        run_req("r7_gate_hi",  8'h33, 8'h33, 7'b1000000, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2);
        run_req("r8_even_par", 8'h00, 8'h00, 7'b1111110, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2);

        // Stall in OUT with a competing in_valid
        bus.out_ready = 1'b0;
        bus.tag_a     = 8'h5A;
        bus.tag_b     = 8'h5A;
        bus.par_vec   = 7'b0000000;
        bus.gate_n    = 4'b0000;
        bus.sel_hold  = 1'b0;
        bus.in_valid  = 1'b1;
        @(negedge CK);
        bus.in_valid = 1'b0;
        w = 0;
        while (!bus.out_valid && w < 20) begin
            @(negedge CK);
            w++;
        end
        check("stall/reach_out", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b1;
        bus.tag_b    = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(negedge CK);
            check("stall/out_valid", 32'(bus.out_valid), 32'd1);
            check("stall/q",         32'(bus.q), 32'd1);
            check("stall/match",     32'(bus.match), 32'd1);
            check("stall/in_ready",  32'(bus.in_ready), 32'd0);
        end
        check("stall/err_cnt", 32'(bus.err_cnt), 32'd2);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge CK);
        check("stall/release_valid", 32'(bus.out_valid), 32'd0);
        check("stall/release_ready", 32'(bus.in_ready), 32'd1);

        // Back-to-back accepts with in_valid held high
        bus.tag_a    = 8'h11;
        bus.tag_b    = 8'h11;
        bus.par_vec  = 7'b0000000;
        bus.in_valid = 1'b1;
        n    = 0;
        prev = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            if (bus.in_ready) begin
                if (n > 0) check("b2b/spacing", 32'(c - prev), 32'd5);
                prev = c;
                n++;
            end
            if (n < 4) @(negedge CK);
        end
        check("b2b/accepts", 32'(n), 32'd4);
        @(negedge CK);
        bus.in_valid = 1'b0;
        w = 0;
        while (!bus.out_valid && w < 20) begin
            @(negedge CK);
            w++;
        end
        check("b2b/q", 32'(bus.q), 32'd1);
        @(negedge CK);

        // 300 mismatching requests saturate the error count
        bus.tag_a    = 8'h5A;
        bus.tag_b    = 8'h5B;
        bus.par_vec  = 7'b0000000;
        bus.gate_n   = 4'b0000;
        bus.sel_hold = 1'b0;
        bus.in_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 2000 && n < 300; c++) begin
            @(negedge CK);
            if (bus.in_ready) n++;
        end
        @(negedge CK);
        bus.in_valid = 1'b0;
        check("sat/accepts", 32'(n), 32'd300);
        w = 0;
        while (!bus.out_valid && w < 20) begin
            @(negedge CK);
            w++;
        end
        check("sat/err_cnt", 32'(bus.err_cnt), 32'd255);
        check("sat/q",       32'(bus.q), 32'd0);
        @(negedge CK);
        run_req("sat_nowrap", 8'h5A, 8'h5B, 7'b1010101, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd255);

        // Reset asserted while the request sits in PAR
        bus.tag_a    = 8'h5A;
        bus.tag_b    = 8'h5A;
        bus.par_vec  = 7'b0000000;
        bus.in_valid = 1'b1;
        @(negedge CK);
        bus.in_valid = 1'b0;
        @(negedge CK);
        check("rpar/match_before", 32'(bus.match), 32'd1);
        RSTN = 1'b0;
        #1;
        check("rpar/match",     32'(bus.match), 32'd0);
        check("rpar/q",         32'(bus.q), 32'd0);
        check("rpar/parity",    32'(bus.parity), 32'd0);
        check("rpar/err_cnt",   32'(bus.err_cnt), 32'd0);
        check("rpar/out_valid", 32'(bus.out_valid), 32'd0);
        check("rpar/in_ready",  32'(bus.in_ready), 32'd0);
        @(negedge CK);
        RSTN = 1'b1;
        #1;
        check("rpar/ready_pre", 32'(bus.in_ready), 32'd0);
        @(negedge CK);
        check("rpar/ready_post", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge CK);
            check("rpar/no_valid", 32'(bus.out_valid), 32'd0);
        end
        check("rpar/q_after",   32'(bus.q), 32'd0);
        check("rpar/err_after", 32'(bus.err_cnt), 32'd0);
        run_req("post_rst", 8'h5A, 8'h5A, 7'b0000011, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
